hex_display_scan: RTL
=====================

Name: hex_display_scan

Overview:
- Consumes a 32-bit value, such as the free-running counter output, and shows it as 8 hex digits on a multiplexed, common-anode, 7-segment display.
- Captures the value into a shadow register on a load strobe.
- Time-multiplexes the digits with a programmable prescaler.
- Sits between the datapath value and the board's anode/cathode pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit stays active; minimum 1, where 1 means advance every cycle.
- PRE_W, 17: prescaler width; must satisfy 2^PRE_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- din  input  32  value to display; nibble i drives digit i (digit 0 = din[3:0], rightmost).
- load  input  1  capture din into the shadow register this cycle.
- blank_lz  input  1  1 = blank leading-zero digits.
- an  output  8  digit enables, active-low, one-hot-low while scanning.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; constant 1 (off).
- digit_tick  output  1  one-cycle pulse when the scan advances to the next digit.

Behaviour:
- Synchronous reset, applied when rst=1 at posedge:
  - shadow=0, idx=0, prescaler=0
  - an=8'hFF, seg=7'h7F, dp=1, digit_tick=0
  - Reset mid-scan aborts immediately. Scanning restarts at digit 0 on the first cycle after rst deasserts.
- Shadow register:
  - load=1 -> shadow<=din at that posedge.
  - load is level-sensitive; holding it high tracks din every cycle.
  - load is ignored while rst=1.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - Terminal count is pre==REFRESH_DIV-1. At that count: idx<=idx+1 mod 8 (7 wraps to 0) and digit_tick<=1 for one cycle; otherwise digit_tick<=0.
  - REFRESH_DIV=1: terminal count every cycle, and digit_tick is held high.
- Output register (all outputs registered, no combinational paths to pins):
  - Each non-reset cycle: an<=~(8'b1<<idx), seg<=decode(shadow[4*idx+:4]) or 7'h7F if blanked.
  - Latency: load at edge N -> new value on seg/an after edge N+1 (when its digit is selected).
  - idx change at edge N -> an/seg for the new digit after edge N+1.
  - digit_tick and the idx change occur on the same edge.
- Leading-zero blanking:
  - Digit i (i=1..7) is blanked when blank_lz=1 and nibbles 7..i of shadow are all zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - A blanked digit keeps its an line low (timing uniform) with seg=7'h7F.
- Decode table, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- Simultaneous events:
  - load on a terminal-count cycle: the output register uses the pre-load shadow on that edge; the new value appears from the next edge.
  - rst has priority over load and over prescaler/idx updates.
- No tearing guarantee beyond per-digit: different digits can show values from different loads during one scan frame; this is acceptable.

Test Plan:
- Reset: hold rst 3 cycles with load=1, din=32'hFFFFFFFF -> an=FF, seg=7F, dp=1, digit_tick=0 throughout; shadow remains 0 (first digit after release shows seg=40).
- Full scan (REFRESH_DIV=1): load din=32'h0123ABCD, blank_lz=0 -> successive cycles an=FE,FD,FB,F7,EF,DF,BF,7F with seg=21,46,03,08,30,24,79,40; wraps back to an=FE.
- Prescaler (REFRESH_DIV=4): after reset, digit_tick pulses every 4th cycle; an holds each pattern exactly 4 cycles; idx 7->0 wrap verified.
- Blanking: shadow=32'h000000A5, blank_lz=1 -> digits 0,1 show seg=12,08; digits 2..7 show seg=7F with an still strobing. Shadow=0 -> digit 0 shows 40, others 7F. blank_lz=0 -> all zero digits show 40.
- Load/tick collision (REFRESH_DIV=1): shadow=32'h11111111, load din=32'h22222222 on a cycle -> the next output shows 79 and the following one shows 24.
- Mid-scan reset: assert rst while idx=5 -> next cycle an=FF; after release, the scan resumes at an=FE with prescaler restarted from 0.

Source files
------------

// File: rtl/hex_display_scan_if.sv
// Signal bundle between the datapath value source and the 7-segment scan driver.
// The master supplies the value and load/blank controls; the slave drives the display pins.
interface hex_display_scan_if;
    logic [31:0] din;
    logic        load;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        digit_tick;

    modport master (
        output din, load, blank_lz,
        input  an, seg, dp, digit_tick
    );

    modport slave (
        input  din, load, blank_lz,
        output an, seg, dp, digit_tick
    );
endinterface

// File: rtl/hex_display_scan.sv
// Shows a 32-bit shadowed value as 8 hex digits on a multiplexed common-anode
// 7-segment display, with programmable refresh prescaler and leading-zero blanking.
module hex_display_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned PRE_W       = 17
) (
    input logic               clk,
    input logic               rst,
    hex_display_scan_if.slave bus
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [31:0]      shadow;
    logic [2:0]       idx;
    logic [PRE_W-1:0] pre;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic             tick_q;

    logic [7:0] lz;
    logic [3:0] nib;
    logic       blanked;
    logic       terminal;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // lz[i]: nibbles 7..i of the shadow are all zero; digit 0 is never blanked.
    always_comb begin
        lz = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            lz[i] = ((shadow >> (4 * i)) == '0);
        end
    end

    assign nib      = shadow[{idx, 2'b00} +: 4];
    assign blanked  = bus.blank_lz && (idx != 3'd0) && lz[idx];
    assign terminal = (pre == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            idx    <= '0;
            pre    <= '0;
            an_q   <= '1;
            seg_q  <= '1;
            tick_q <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow <= bus.din;
            end
            if (terminal) begin
                pre    <= '0;
                idx    <= idx + 3'd1;
                tick_q <= 1'b1;
            end else begin
                pre    <= pre + 1'b1;
                tick_q <= 1'b0;
            end
            // Output register samples the pre-load shadow and pre-advance idx.
            an_q  <= ~(8'b1 << idx);
            seg_q <= blanked ? 7'h7F : decode(nib);
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.digit_tick = tick_q;

endmodule
